// File: rtl/modulo_updown_counter_pkg.sv
// Shared desk-clock timebase definitions: count direction and the standard
// moduli used by the seconds/minutes/hours/day-of-week digit groups.
package modulo_updown_counter_pkg;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned HR24_MOD = 24;
  localparam int unsigned HR12_MOD = 12;
  localparam int unsigned DOW_MOD  = 7;

endpackage

// File: rtl/modulo_updown_counter.sv
// Cascadable up/down modulo counter with programmable modulus, synchronous
// load/clear, zero-latency carry/borrow and a sticky wrap flag.
module modulo_updown_counter
  import modulo_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_MOD = SEC_MOD
) (
  input  logic             i_sysclk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_mod_we,
  input  logic [WIDTH-1:0] i_mod,
  input  logic             i_wrap_ack,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_mod,
  output logic             o_carry,
  output logic             o_wrap_sticky
);

  localparam logic [WIDTH-1:0] RST_MOD = WIDTH'(RESET_MOD);
  localparam logic [WIDTH:0]   FULL_M  = {1'b1, {WIDTH{1'b0}}};

  // Modulus arithmetic is carried in WIDTH+1 bits so a zero modulus can
  // stand for 2^WIDTH without truncating Last.
  logic [WIDTH:0]   eff_m;
  logic [WIDTH:0]   last;
  logic [WIDTH:0]   new_m;
  logic [WIDTH:0]   count_ext;
  logic             at_top;
  logic             at_zero;
  logic             wrap;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] mod_d;
  logic             sticky_d;

  always_comb begin
    eff_m     = (o_mod == '0) ? FULL_M : {1'b0, o_mod};
    last      = eff_m - 1'b1;
    new_m     = (i_mod == '0) ? FULL_M : {1'b0, i_mod};
    count_ext = {1'b0, o_count};
    at_top    = (count_ext >= last);
    at_zero   = (o_count == '0);
    wrap      = ~i_reset & i_en & ~i_clear & ~i_load & ~i_mod_we &
                ((i_dir == DIR_UP) ? at_top : at_zero);
  end

  assign o_carry = wrap;

  always_comb begin
    count_d  = o_count;
    mod_d    = o_mod;
    sticky_d = o_wrap_sticky;

    if (i_clear) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = ({1'b0, i_load_val} < eff_m) ? i_load_val : last[WIDTH-1:0];
    end else if (i_mod_we) begin
      mod_d = i_mod;
      if (count_ext >= new_m) count_d = '0;
    end else if (i_en) begin
      // The >= on the up path also pulls an out-of-range count back to 0.
      if (i_dir == DIR_UP) count_d = at_top  ? '0               : o_count + 1'b1;
      else                 count_d = at_zero ? last[WIDTH-1:0]  : o_count - 1'b1;
    end

    if (wrap)            sticky_d = 1'b1;
    else if (i_wrap_ack) sticky_d = 1'b0;
  end

  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      o_count       <= '0;
      o_mod         <= RST_MOD;
      o_wrap_sticky <= 1'b0;
    end else begin
      o_count       <= count_d;
      o_mod         <= mod_d;
      o_wrap_sticky <= sticky_d;
    end
  end

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Randomized and directed check of modulo_updown_counter against an
// arithmetic reference model, plus a seconds->minutes chain.
module tb_modulo_updown_counter;

  logic       i_sysclk = 1'b0;
  logic       i_reset  = 1'b1;
  logic       i_en = 1'b0, i_dir = 1'b0, i_clear = 1'b0, i_load = 1'b0;
  logic [7:0] i_load_val = '0;
  logic       i_mod_we = 1'b0;
  logic [7:0] i_mod = '0;
  logic       i_wrap_ack = 1'b0;
  logic [7:0] o_count, o_mod;
  logic       o_carry, o_wrap_sticky;

  logic [7:0] min_count, min_mod;
  logic       min_carry, min_sticky;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned m_cnt, m_mod;
  bit          m_sticky;
  bit          m_carry;

  always #5 i_sysclk = ~i_sysclk;

  modulo_updown_counter #(.WIDTH(8), .RESET_MOD(60)) dut (
    .i_sysclk(i_sysclk), .i_reset(i_reset), .i_en(i_en), .i_dir(i_dir),
    .i_clear(i_clear), .i_load(i_load), .i_load_val(i_load_val),
    .i_mod_we(i_mod_we), .i_mod(i_mod), .i_wrap_ack(i_wrap_ack),
    .o_count(o_count), .o_mod(o_mod), .o_carry(o_carry),
    .o_wrap_sticky(o_wrap_sticky)
  );

  modulo_updown_counter #(.WIDTH(8), .RESET_MOD(60)) dut_min (
    .i_sysclk(i_sysclk), .i_reset(i_reset), .i_en(o_carry), .i_dir(1'b0),
    .i_clear(1'b0), .i_load(1'b0), .i_load_val(8'd0),
    .i_mod_we(1'b0), .i_mod(8'd0), .i_wrap_ack(1'b0),
    .o_count(min_count), .o_mod(min_mod), .o_carry(min_carry),
    .o_wrap_sticky(min_sticky)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned eff(input int unsigned m);
    return (m == 0) ? 256 : m;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mod = 60; m_sticky = 0;
  endtask

  // One clock: check the combinational carry, advance the model, check state.
  task automatic step();
    int unsigned big_m, new_m;
    #1;
    big_m   = eff(m_mod);
    m_carry = i_en && !i_clear && !i_load && !i_mod_we &&
              (i_dir ? (m_cnt == 0) : (m_cnt == big_m - 1));
    chk("carry", o_carry, m_carry);
    if (i_clear)       m_cnt = 0;
    else if (i_load)   m_cnt = (i_load_val < big_m) ? i_load_val : big_m - 1;
    else if (i_mod_we) begin
      m_mod = i_mod;
      new_m = eff(m_mod);
      if (m_cnt >= new_m) m_cnt = 0;
    end else if (i_en) m_cnt = i_dir ? (m_cnt + big_m - 1) % big_m : (m_cnt + 1) % big_m;
    if (m_carry)         m_sticky = 1;
    else if (i_wrap_ack) m_sticky = 0;
    @(posedge i_sysclk);
    #1;
    chk("count", o_count, m_cnt);
    chk("mod", o_mod, m_mod);
    chk("sticky", o_wrap_sticky, m_sticky);
  endtask

  task automatic idle();
    i_en = 0; i_clear = 0; i_load = 0; i_mod_we = 0; i_wrap_ack = 0;
  endtask

  task automatic do_load(input int unsigned v);
    idle(); i_load = 1; i_load_val = 8'(v); step(); idle();
  endtask

  task automatic do_mod(input int unsigned v, input bit en);
    idle(); i_mod_we = 1; i_mod = 8'(v); i_en = en; step(); idle();
  endtask

  initial begin
    int unsigned min_exp_cnt, min_carries, r;
    model_reset();
    #12;
    chk("rst_count", o_count, 0);
    chk("rst_mod", o_mod, 60);
    chk("rst_sticky", o_wrap_sticky, 0);
    i_en = 1; i_dir = 1; #1;
    chk("rst_carry", o_carry, 0);
    idle(); i_dir = 0;
    @(posedge i_sysclk); #1;
    i_reset = 0;

    // Up-count through one full wrap at M=60, then acknowledge.
    i_en = 1; i_dir = 0;
    for (int i = 0; i < 61; i++) step();
    chk("up_sticky_set", o_wrap_sticky, 1);
    chk("up_count_after", o_count, 1);
    idle(); i_wrap_ack = 1; step(); idle();
    chk("ack_clears", o_wrap_sticky, 0);

    // Down-count at M=24 from 0.
    idle(); i_clear = 1; step();
    do_mod(24, 0);
    i_en = 1; i_dir = 1;
    #1; chk("dn_borrow_at0", o_carry, 1);
    step();
    chk("dn_0_to_23", o_count, 23);
    for (int i = 0; i < 30; i++) step();
    idle(); i_dir = 0;

    // Load / clear priority and clamping.
    do_mod(60, 0);
    do_load(45); chk("load45", o_count, 45);
    do_load(75); chk("load75_clamp", o_count, 59);
    idle(); i_en = 1; i_load = 1; i_load_val = 8'd59; step();
    idle(); i_en = 1; i_clear = 1; i_load = 1; i_load_val = 8'd20; step();
    chk("clear_beats_load", o_count, 0);
    idle();

    // Modulus change while counting.
    do_load(30); do_mod(24, 1); chk("mod24_zeroes", o_count, 0); chk("mod24_val", o_mod, 24);
    do_load(10); do_mod(60, 1); chk("mod60_keeps", o_count, 10);

    // M=1 and M=2^WIDTH.
    do_mod(1, 0);
    for (int i = 0; i < 12; i++) begin
      i_en = 1'($urandom_range(0, 1)); i_dir = 1'($urandom_range(0, 1)); step();
    end
    idle(); i_dir = 0;
    do_mod(0, 0);
    do_load(255);
    i_en = 1; i_dir = 0; step(); chk("m256_up_wrap", o_count, 0);
    i_dir = 1; step(); chk("m256_dn_wrap", o_count, 255);
    idle(); i_dir = 0;

    // Random mix of every control.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 15);
      i_clear    = (r == 0);
      i_load     = (r == 1) || (r == 2);
      i_mod_we   = (r == 3);
      i_en       = ($urandom_range(0, 3) != 0);
      i_dir      = 1'($urandom_range(0, 1));
      i_wrap_ack = ($urandom_range(0, 7) == 0);
      i_load_val = 8'($urandom);
      case ($urandom_range(0, 4))
        0: i_mod = 8'd0;
        1: i_mod = 8'd1;
        2: i_mod = 8'd24;
        3: i_mod = 8'd60;
        default: i_mod = 8'($urandom_range(2, 255));
      endcase
      step();
    end
    idle(); i_dir = 0;

    // Async reset mid-count with sticky set.
    do_mod(60, 0);
    do_load(59);
    i_en = 1; step(); idle();
    do_load(37);
    chk("pre_rst_sticky", o_wrap_sticky, 1);
    #3; i_reset = 1; #1;
    chk("async_count", o_count, 0);
    chk("async_mod", o_mod, 60);
    chk("async_sticky", o_wrap_sticky, 0);
    model_reset();
    @(posedge i_sysclk); #1;
    i_reset = 0;
    i_en = 1; step(); chk("resume", o_count, 1);

    // Seconds stage chained into minutes stage.
    idle();
    i_reset = 1; #1; model_reset(); @(posedge i_sysclk); #1; i_reset = 0;
    min_exp_cnt = 0; min_carries = 0;
    i_en = 1; i_dir = 0;
    for (int i = 0; i < 3600; i++) begin
      #1;
      if (min_carry) min_carries++;
      if (o_carry) min_exp_cnt = (min_exp_cnt + 1) % 60;
      step();
    end
    idle();
    chk("chain_min_cnt", min_count, min_exp_cnt);
    chk("chain_min_zero", min_count, 0);
    chk("chain_min_carries", min_carries, 1);
    chk("chain_min_sticky", min_sticky, 1);
    chk("chain_min_mod", min_mod, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
